packet_injector: RTL and testbench

Per-port flit generator inside the traffic-generation layer of the ESYNet RTL NoC model. On a start request it latches a packet descriptor (destination, packet ID, body length), emits the packet as head, body and tail flits, one per clock, into a router input port under credit-based flow control. It then pulses a completion flag. It is driven by the random-injection wrapper, which holds the start request high until completion.

---
 rtl/packet_injector_pkg.sv | 46 ++++
 rtl/packet_injector.sv | 145 ++++++++++++++
 tb/tb_packet_injector.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/packet_injector_pkg.sv
// Shared flit geometry, flit-type codes and the flit assembly helper
// for the packet injector.
package packet_injector_pkg;

    localparam int FLIT_WIDTH       = 32;
    localparam int FLIT_DST_WIDTH   = 4;
    localparam int FLIT_ID_WIDTH    = 8;
    localparam int BUFFERSIZE_WIDTH = 4;
    localparam int BODYFLITAMOUNT   = 8;

    localparam int TYPE_WIDTH = 2;
    localparam int TYPE_LSB   = FLIT_WIDTH - TYPE_WIDTH;
    localparam int SRC_LSB    = TYPE_LSB - FLIT_DST_WIDTH;
    localparam int DST_LSB    = SRC_LSB - FLIT_DST_WIDTH;
    localparam int ID_LSB     = DST_LSB - FLIT_ID_WIDTH;
    localparam int SEQ_WIDTH  = ID_LSB;

    // One extra bit so the tail index (amount + 1) never wraps.
    localparam int CNT_WIDTH = BUFFERSIZE_WIDTH + 1;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_TAIL = 2'b01,
        FLIT_HEAD = 2'b10
    } flit_type_e;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    function automatic flit_t make_flit(
        input flit_type_e                ftype,
        input logic [FLIT_DST_WIDTH-1:0] src,
        input logic [FLIT_DST_WIDTH-1:0] dst,
        input logic [FLIT_ID_WIDTH-1:0]  id,
        input logic [CNT_WIDTH-1:0]      seq
    );
        flit_t f;
        f = '0;
        f[TYPE_LSB +: TYPE_WIDTH]    = ftype;
        f[SRC_LSB +: FLIT_DST_WIDTH] = src;
        f[DST_LSB +: FLIT_DST_WIDTH] = dst;
        f[ID_LSB +: FLIT_ID_WIDTH]   = id;
        f[SEQ_WIDTH-1:0]             = SEQ_WIDTH'(seq);
        return f;
    endfunction

endpackage

// File: rtl/packet_injector.sv
// Per-port head/body/tail flit generator with credit flow control.
// Define PACKET_INJECTOR_TRACE_EN for simulation-only start/tail trace.
module packet_injector
    import packet_injector_pkg::*;
#(
    parameter int P_LOCAL_ID = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        startSignal,
    input  logic [FLIT_DST_WIDTH-1:0]   packet_destination,
    input  logic [FLIT_ID_WIDTH-1:0]    packet_id,
    input  logic [BUFFERSIZE_WIDTH-1:0] flit_amount,
    input  logic [BUFFERSIZE_WIDTH-1:0] credit_feedback,
    output logic                        data_valid,
    output logic [FLIT_WIDTH-1:0]       data_out,
    output logic                        finished
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [FLIT_DST_WIDTH-1:0] SRC_ID =
        FLIT_DST_WIDTH'(P_LOCAL_ID);

    if (FLIT_WIDTH < TYPE_WIDTH + 2 * FLIT_DST_WIDTH + FLIT_ID_WIDTH)
    begin : g_width_chk
        $error("packet_injector: FLIT_WIDTH too small for flit fields");
    end

    logic [1:0]                  state_q, state_d;
    logic                        start_prev_q, start_prev_d;
    logic [FLIT_DST_WIDTH-1:0]   dst_q, dst_d;
    logic [FLIT_ID_WIDTH-1:0]    id_q, id_d;
    logic [BUFFERSIZE_WIDTH-1:0] amount_q, amount_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        data_valid_q, data_valid_d;
    logic [FLIT_WIDTH-1:0]       data_out_q, data_out_d;
    logic                        finished_q, finished_d;

    logic                        start_rise;
    logic                        has_credit;
    logic [CNT_WIDTH-1:0]        last_idx;
    flit_type_e                  ftype;

    assign start_rise = startSignal & ~start_prev_q;
    assign has_credit = (credit_feedback != '0);
    assign last_idx   = CNT_WIDTH'(amount_q) + CNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        start_prev_d = startSignal;
        dst_d        = dst_q;
        id_d         = id_q;
        amount_d     = amount_q;
        cnt_d        = cnt_q;
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        finished_d   = 1'b0;

        ftype = FLIT_BODY;
        if (cnt_q == '0) begin
            ftype = FLIT_HEAD;
        end else if (cnt_q == last_idx) begin
            ftype = FLIT_TAIL;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    dst_d    = packet_destination;
                    id_d     = packet_id;
                    amount_d = flit_amount;
                    cnt_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // Without credit the last flit stays on data_out.
                if (has_credit) begin
                    data_valid_d = 1'b1;
                    data_out_d   = make_flit(ftype, SRC_ID, dst_q,
                                             id_q, cnt_q);
                    cnt_d        = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == last_idx) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            dst_q        <= '0;
            id_q         <= '0;
            amount_q     <= '0;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            dst_q        <= dst_d;
            id_q         <= id_d;
            amount_q     <= amount_d;
            cnt_q        <= cnt_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            finished_q   <= finished_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign finished   = finished_q;

`ifdef PACKET_INJECTOR_TRACE_EN
    always @(posedge CLK) begin
        if (!RST && state_q == ST_IDLE && start_rise) begin
            $display("%0t: injector %0d start id=%0d size=%0d dst=%0d",
                     $time, P_LOCAL_ID, packet_id,
                     int'(flit_amount) + 2, packet_destination);
        end
        if (!RST && state_q == ST_SEND && has_credit
            && cnt_q == last_idx) begin
            $display("%0t: injector %0d tail id=%0d",
                     $time, P_LOCAL_ID, id_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Directed table-driven bench for packet_injector (P_LOCAL_ID = 2).
module tb_packet_injector;

    localparam logic [1:0] TH = 2'b10;
    localparam logic [1:0] TB = 2'b00;
    localparam logic [1:0] TT = 2'b01;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        startSignal = 1'b0;
    logic [3:0]  dst = '0;
    logic [7:0]  pid = '0;
    logic [3:0]  amt = '0;
    logic [3:0]  credit = '0;
    logic        data_valid;
    logic [31:0] data_out;
    logic        finished;

    int n_vec = 0;
    int n_bad = 0;

    packet_injector #(.P_LOCAL_ID(2)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .startSignal        (startSignal),
        .packet_destination (dst),
        .packet_id          (pid),
        .flit_amount        (amt),
        .credit_feedback    (credit),
        .data_valid         (data_valid),
        .data_out           (data_out),
        .finished           (finished)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s;
        logic [3:0]  c;
        logic [3:0]  d;
        logic [3:0]  a;
        logic [7:0]  i;
        logic        ev;
        logic        ef;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] fl(input logic [1:0] t,
                                       input logic [3:0] d,
                                       input logic [7:0] i,
                                       input int seq);
        return {t, 4'd2, d, i, seq[13:0]};
    endfunction

    function automatic void add(input logic s, input logic [3:0] c,
                                input logic [3:0] d, input logic [3:0] a,
                                input logic [7:0] i, input logic ev,
                                input logic ef, input logic [31:0] ed);
        vec_t v;
        v.s = s; v.c = c; v.d = d; v.a = a; v.i = i;
        v.ev = ev; v.ef = ef; v.ed = ed;
        tbl.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic s,
                         input logic [3:0] c, input logic [3:0] d,
                         input logic [3:0] a, input logic [7:0] i);
        RST = r;
        startSignal = s;
        credit = c;
        dst = d;
        amt = a;
        pid = i;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic ev,
                         input logic ef, input logic [31:0] ed);
        n_vec++;
        if (data_valid !== ev || finished !== ef || data_out !== ed) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b fin=%0b data=%h, want valid=%0b fin=%0b data=%h",
                     nm, data_valid, finished, data_out, ev, ef, ed);
        end
    endtask

    logic [31:0] t;

    initial begin
        // Basic packet; descriptor changes after the start edge.
        add(1, 4, 5, 3, 8'h12, 0, 0, 32'h0);
        add(1, 4, 9, 1, 8'h77, 1, 0, fl(TH, 5, 8'h12, 0));
        add(1, 4, 9, 1, 8'h77, 1, 0, fl(TB, 5, 8'h12, 1));
        add(1, 4, 9, 1, 8'h77, 1, 0, fl(TB, 5, 8'h12, 2));
        add(1, 4, 9, 1, 8'h77, 1, 0, fl(TB, 5, 8'h12, 3));
        add(1, 4, 9, 1, 8'h77, 1, 0, fl(TT, 5, 8'h12, 4));
        add(1, 4, 9, 1, 8'h77, 0, 1, fl(TT, 5, 8'h12, 4));
        add(1, 4, 9, 1, 8'h77, 0, 0, fl(TT, 5, 8'h12, 4));
        add(1, 4, 9, 1, 8'h77, 0, 0, fl(TT, 5, 8'h12, 4));
        add(0, 4, 9, 1, 8'h77, 0, 0, fl(TT, 5, 8'h12, 4));
        // Minimal packet.
        add(1, 1, 3, 0, 8'h5a, 0, 0, fl(TT, 5, 8'h12, 4));
        add(0, 1, 3, 0, 8'h5a, 1, 0, fl(TH, 3, 8'h5a, 0));
        add(0, 1, 3, 0, 8'h5a, 1, 0, fl(TT, 3, 8'h5a, 1));
        add(0, 1, 3, 0, 8'h5a, 0, 1, fl(TT, 3, 8'h5a, 1));
        add(0, 1, 3, 0, 8'h5a, 0, 0, fl(TT, 3, 8'h5a, 1));
        // Backpressure in packet cycles 2..4.
        add(1, 2, 7, 2, 8'h33, 0, 0, fl(TT, 3, 8'h5a, 1));
        add(0, 2, 7, 2, 8'h33, 1, 0, fl(TH, 7, 8'h33, 0));
        add(0, 0, 7, 2, 8'h33, 0, 0, fl(TH, 7, 8'h33, 0));
        add(0, 0, 7, 2, 8'h33, 0, 0, fl(TH, 7, 8'h33, 0));
        add(0, 0, 7, 2, 8'h33, 0, 0, fl(TH, 7, 8'h33, 0));
        add(0, 2, 7, 2, 8'h33, 1, 0, fl(TB, 7, 8'h33, 1));
        add(0, 2, 7, 2, 8'h33, 1, 0, fl(TB, 7, 8'h33, 2));
        add(0, 2, 7, 2, 8'h33, 1, 0, fl(TT, 7, 8'h33, 3));
        add(0, 2, 7, 2, 8'h33, 0, 1, fl(TT, 7, 8'h33, 3));
        add(0, 2, 7, 2, 8'h33, 0, 0, fl(TT, 7, 8'h33, 3));

        // Reset held with start high, released together with start low.
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 4, 5, 3, 8'h12);
            check("reset", 0, 0, 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 4, 5, 3, 8'h12);
            check("post_reset_idle", 0, 0, 32'h0);
        end

        for (int k = 0; k < tbl.size(); k++) begin
            apply(0, tbl[k].s, tbl[k].c, tbl[k].d, tbl[k].a, tbl[k].i);
            check($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ef, tbl[k].ed);
        end

        // Restart edge mid-packet, then start held high after finished.
        t = fl(TT, 7, 8'h33, 3);
        apply(0, 1, 4, 1, 2, 8'h44);
        check("rs_start", 0, 0, t);
        apply(0, 0, 4, 1, 2, 8'h44);
        check("rs_head", 1, 0, fl(TH, 1, 8'h44, 0));
        apply(0, 1, 4, 2, 0, 8'h99);
        check("rs_body1", 1, 0, fl(TB, 1, 8'h44, 1));
        apply(0, 1, 4, 2, 0, 8'h99);
        check("rs_body2", 1, 0, fl(TB, 1, 8'h44, 2));
        apply(0, 1, 4, 2, 0, 8'h99);
        check("rs_tail", 1, 0, fl(TT, 1, 8'h44, 3));
        t = fl(TT, 1, 8'h44, 3);
        apply(0, 1, 4, 2, 0, 8'h99);
        check("rs_fin", 0, 1, t);
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 4, 2, 0, 8'h99);
            check("rs_held", 0, 0, t);
        end
        apply(0, 0, 4, 2, 0, 8'h99);
        check("rs_low", 0, 0, t);

        // Reset after the head flit, then a clean packet.
        apply(0, 1, 4, 6, 3, 8'h21);
        check("mr_start", 0, 0, t);
        apply(0, 0, 4, 6, 3, 8'h21);
        check("mr_head", 1, 0, fl(TH, 6, 8'h21, 0));
        apply(1, 0, 4, 6, 3, 8'h21);
        check("mr_reset", 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 4, 6, 3, 8'h21);
            check("mr_nofin", 0, 0, 32'h0);
        end
        apply(0, 1, 4, 6, 3, 8'h21);
        check("mr_restart", 0, 0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 4, 6, 3, 8'h21);
            check("mr_flit", 1, 0,
                  fl(k == 0 ? TH : (k == 4 ? TT : TB), 6, 8'h21, k));
        end
        t = fl(TT, 6, 8'h21, 4);
        apply(0, 0, 4, 6, 3, 8'h21);
        check("mr_fin", 0, 1, t);
        apply(0, 0, 4, 6, 3, 8'h21);
        check("mr_idle", 0, 0, t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
